// File: rtl/block_update_tx.sv
// block_update_tx: strobed 10-bit block-update bus transmitter with a small write FIFO
// Optional feature macro: BLOCK_TX_CLEAR_EN adds clear_req and a 256-block zero sweep.
// Ports:
//   CLOCK_50, reset        clock, synchronous active-high reset
//   req_valid, req_ready   write handshake (push when both high)
//   req_x, req_y, req_value  block column, row and value of the write
//   clear_req              one-cycle sweep request (BLOCK_TX_CLEAR_EN only)
//   busy                   queued writes, frame in flight, or sweep pending/active
//   DATA_OUT, ENABLE_OUT   frame {x, y, value} and its strobe
module block_update_tx #(
    parameter int FIFO_AW       = 2,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_x,
    input  logic [3:0] req_y,
    input  logic [1:0] req_value,
`ifdef BLOCK_TX_CLEAR_EN
    input  logic       clear_req,
`endif
    output logic       busy,
    output logic [9:0] DATA_OUT,
    output logic       ENABLE_OUT
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;

    localparam int DEPTH = 1 << FIFO_AW;

    state_t           r_state, w_state_nx;
    logic [7:0]       r_cnt, w_cnt_nx;
    logic [9:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr, r_rptr;
    logic [9:0]       r_frame;
    logic [9:0]       w_sweep_frame;
    logic             w_empty, w_full, w_push, w_pop, w_start, w_sweep;

    assign w_empty   = r_wptr == r_rptr;
    assign w_full    = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                       (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_push    = req_valid && !w_full;
    assign w_start   = (r_state == S_IDLE) && (w_sweep || !w_empty);
    // the sweep outranks the FIFO, so queued writes stay put until it ends
    assign w_pop     = w_start && !w_sweep;
    assign req_ready = !w_full;
    assign busy      = !w_empty || (r_state != S_IDLE) || w_sweep;
    assign DATA_OUT  = r_frame;

`ifdef BLOCK_TX_CLEAR_EN
    logic       r_clr_pend, r_clr_act;
    logic [7:0] r_idx;

    assign w_sweep       = r_clr_pend || r_clr_act;
    assign w_sweep_frame = {r_idx, 2'b00};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_clr_pend <= 1'b0;
            r_clr_act  <= 1'b0;
            r_idx      <= 8'd0;
        end else if (w_start && w_sweep) begin
            // r_idx wraps back to 0 after block 255, ready for the next sweep
            r_clr_pend <= 1'b0;
            r_clr_act  <= r_idx != 8'hff;
            r_idx      <= r_idx + 8'd1;
        end else if (clear_req && !r_clr_act) begin
            r_clr_pend <= 1'b1;
        end
    end
`else
    assign w_sweep       = 1'b0;
    assign w_sweep_frame = 10'd0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_frame <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + (FIFO_AW + 1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (FIFO_AW + 1)'(1);
            if (w_start)
                r_frame <= w_sweep ? w_sweep_frame : r_mem[r_rptr[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_push)
            r_mem[r_wptr[FIFO_AW-1:0]] <= {req_x, req_y, req_value};
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // each timed state is entered with its length minus one and left when the count hits 0
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt - 8'd1;
        ENABLE_OUT = 1'b0;
        case (r_state)
            S_IDLE:
                if (w_start) begin
                    w_state_nx = S_SETUP;
                    w_cnt_nx   = 8'(SETUP_CYCLES - 1);
                end
            S_SETUP:
                if (r_cnt == 8'd0) begin
                    w_state_nx = S_STROBE;
                    w_cnt_nx   = 8'(STROBE_CYCLES - 1);
                end
            S_STROBE: begin
                ENABLE_OUT = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = 8'(HOLD_CYCLES - 1);
                end
            end
            S_HOLD:
                if (r_cnt == 8'd0) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = 8'(GAP_CYCLES - 1);
                end
            S_GAP:
                if (r_cnt == 8'd0)
                    w_state_nx = S_IDLE;
            default:
                w_state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_block_update_tx.sv
// tb_block_update_tx: default and minimum-timing transmitters against a frame-timeline model
module tb_block_update_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid;
    logic [3:0] req_x, req_y;
    logic [1:0] req_value;
`ifdef BLOCK_TX_CLEAR_EN
    logic       clr;
`endif
    logic       rdy_a, busy_a, en_a, rdy_b, busy_b, en_b;
    logic [9:0] data_a, data_b;

    block_update_tx dut_a (
        .CLOCK_50(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy_a),
        .req_x(req_x), .req_y(req_y), .req_value(req_value),
`ifdef BLOCK_TX_CLEAR_EN
        .clear_req(clr),
`endif
        .busy(busy_a), .DATA_OUT(data_a), .ENABLE_OUT(en_a)
    );

    block_update_tx #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .CLOCK_50(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy_b),
        .req_x(req_x), .req_y(req_y), .req_value(req_value),
`ifdef BLOCK_TX_CLEAR_EN
        .clear_req(clr),
`endif
        .busy(busy_b), .DATA_OUT(data_b), .ENABLE_OUT(en_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int k, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d got=%0h exp=%0h", name, k, got, exp);
        end
    endtask

    // model: a frame is a timeline t = 0..len-1 (setup, strobe, hold, gap); t = -1 is the idle pop slot
    int         PS[2] = '{2, 1};
    int         PT[2] = '{4, 1};
    int         PH[2] = '{2, 1};
    int         PG[2] = '{2, 1};
    int         m_t[2], m_n[2], m_sw[2];
    logic [9:0] m_frame[2];
    logic [9:0] m_q[2][4];
    bit         m_ok = 1'b0;

    always @(posedge clk) begin
        logic acc, clr_acc;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_t[k]     = -1;
                m_n[k]     = 0;
                m_sw[k]    = 0;
                m_frame[k] = 10'd0;
            end else begin
                acc = req_valid && m_n[k] < 4;
`ifdef BLOCK_TX_CLEAR_EN
                clr_acc = clr && m_sw[k] == 0;
`else
                clr_acc = 1'b0;
`endif
                if (m_t[k] < 0) begin
                    if (m_sw[k] > 0) begin
                        m_frame[k] = {8'(256 - m_sw[k]), 2'b00};
                        m_sw[k]--;
                        m_t[k] = 0;
                    end else if (m_n[k] > 0) begin
                        m_frame[k] = m_q[k][0];
                        for (int j = 0; j < 3; j++) m_q[k][j] = m_q[k][j+1];
                        m_n[k]--;
                        m_t[k] = 0;
                    end
                end else begin
                    m_t[k]++;
                    if (m_t[k] == PS[k] + PT[k] + PH[k] + PG[k]) m_t[k] = -1;
                end
                if (acc) begin
                    m_q[k][m_n[k]] = {req_x, req_y, req_value};
                    m_n[k]++;
                end
                if (clr_acc) m_sw[k] = 256;
            end
        end
        m_ok = 1'b1;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_en", k, int'(k == 0 ? en_a : en_b),
                    int'(m_t[k] >= PS[k] && m_t[k] < PS[k] + PT[k]));
                chk("model_data", k, int'(k == 0 ? data_a : data_b), int'(m_frame[k]));
                chk("model_ready", k, int'(k == 0 ? rdy_a : rdy_b), int'(m_n[k] < 4));
                chk("model_busy", k, int'(k == 0 ? busy_a : busy_b),
                    int'(m_t[k] >= 0 || m_n[k] > 0 || m_sw[k] > 0));
            end
        end
    end

    logic [9:0] cap[$];
    int         cap_t[$];
    bit         cap_on = 1'b0;
    logic       en_prev = 1'b0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cap_on && en_a && !en_prev) begin
            cap.push_back(data_a);
            cap_t.push_back(cyc);
        end
        en_prev <= en_a;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst = 1'b1; req_valid = 1'b0; req_x = 4'd0; req_y = 4'd0; req_value = 2'd0;
`ifdef BLOCK_TX_CLEAR_EN
        clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 0, int'(rdy_a), 1);
        chk("rst_busy", 0, int'(busy_a), 0);
        chk("rst_data", 0, int'(data_a), 0);
        chk("rst_en", 0, int'(en_a), 0);

        // single write x=3 y=5 v=2; j counts negedges after the accepting edge
        @(negedge clk);
        req_valid = 1'b1; req_x = 4'd3; req_y = 4'd5; req_value = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            if (j > 1) @(negedge clk);
            if (j >= 2 && j <= 11) chk("single_data", 0, int'(data_a), int'(10'b0011_0101_10));
            chk("single_en", 0, int'(en_a), int'(j >= 4 && j <= 7));
            chk("single_busy", 0, int'(busy_a), int'(j <= 11));
            if (j >= 2 && j <= 5) chk("fast_data", 1, int'(data_b), int'(10'b0011_0101_10));
            chk("fast_en", 1, int'(en_b), int'(j == 3));
            chk("fast_busy", 1, int'(busy_b), int'(j <= 5));
        end

        // back-to-back writes with valid held
        cap.delete(); cap_t.delete(); cap_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            {req_x, req_y, req_value} = 10'(i * 37 + 5);
            g = 0;
            while (!rdy_a && g < 40) begin @(negedge clk); g++; end
            @(negedge clk);
            if (i == 4) chk("full_after_5", 0, int'(rdy_a), 0);
        end
        req_valid = 1'b0;
        g = 0;
        while (busy_a && g < 200) begin @(negedge clk); g++; end
        chk("b2b_drain", 0, int'(busy_a), 0);
        chk("b2b_count", 0, cap.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < cap.size()) chk("b2b_order", 0, int'(cap[i]), i * 37 + 5);
            if (i > 0 && i < cap.size()) chk("b2b_period", 0, cap_t[i] - cap_t[i-1], 11);
        end
        cap_on = 1'b0;

        // reset during the strobe of (1,1,1) with two writes still queued
        req_valid = 1'b1; {req_x, req_y, req_value} = {4'd1, 4'd1, 2'd1};
        @(negedge clk);
        {req_x, req_y, req_value} = {4'd4, 4'd4, 2'd0};
        @(negedge clk);
        {req_x, req_y, req_value} = {4'd5, 4'd5, 2'd1};
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (!en_a && g < 20) begin @(negedge clk); g++; end
        chk("rst_test_strobe", 0, int'(en_a), 1);
        chk("rst_test_frame", 0, int'(data_a), int'({4'd1, 4'd1, 2'd1}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_en", 0, int'(en_a), 0);
        chk("midrst_data", 0, int'(data_a), 0);
        chk("midrst_ready", 0, int'(rdy_a), 1);
        chk("midrst_busy", 0, int'(busy_a), 0);
        g = 0;
        repeat (30) begin @(negedge clk); if (en_a) g++; end
        chk("no_frame_after_rst", 0, g, 0);

`ifdef BLOCK_TX_CLEAR_EN
        // clear mid-frame with (15,15,3) queued, then a second clear during the sweep
        cap.delete(); cap_t.delete(); cap_on = 1'b1;
        req_valid = 1'b1; {req_x, req_y, req_value} = {4'd2, 4'd2, 2'd1};
        @(negedge clk);
        {req_x, req_y, req_value} = {4'd15, 4'd15, 2'd3};
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (!en_a && g < 30) begin @(negedge clk); g++; end
        chk("clr_first_strobe", 0, int'(en_a), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (60) @(negedge clk);
        chk("clr_busy_in_sweep", 0, int'(busy_a), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        g = 0;
        while (busy_a && g < 4000) begin @(negedge clk); g++; end
        chk("clr_drain", 0, int'(busy_a), 0);
        chk("clr_count", 0, cap.size(), 258);
        if (cap.size() == 258) begin
            chk("clr_first", 0, int'(cap[0]), int'({4'd2, 4'd2, 2'd1}));
            for (int i = 0; i < 256; i++) chk("clr_sweep", 0, int'(cap[i+1]), i * 4);
            chk("clr_last", 0, int'(cap[257]), int'({4'd15, 4'd15, 2'd3}));
        end
        cap_on = 1'b0;
`endif

        // randomized traffic with occasional resets
        repeat (2500) begin
            @(negedge clk);
            rst = $urandom_range(0, 399) == 0;
            req_valid = $urandom_range(0, 2) == 0;
            {req_x, req_y, req_value} = 10'($urandom);
`ifdef BLOCK_TX_CLEAR_EN
            clr = $urandom_range(0, 799) == 0;
`endif
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
